// File: rtl/mem_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter_if
// Bundles the datapath request/response signals and the single-port RAM
// signals seen by mem_request_arbiter.
//   slave  : the arbiter side (takes requests and RAM status, drives hits,
//            loads, RAM controls and mem_err)
//   master : the datapath + RAM side (drives requests, ramload, ramstate)
// Signals:
//   iREN/iaddr            instruction read request and address
//   dREN/dWEN/daddr/dstore data read/write request, address, write data
//   ihit/iload            instruction completion pulse and fetched word
//   dhit/dload            data completion pulse and loaded word
//   ramREN/ramWEN/ramaddr/ramstore  RAM controls
//   ramload/ramstate      RAM read data and status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   mem_err               sticky error/timeout flag
// ---------------------------------------------------------------------------
interface mem_request_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter
// Serves instruction fetches and data loads/stores from the datapath onto a
// single-port RAM with variable latency. Data requests win over instruction
// requests; each access completes with a one-cycle ihit/dhit pulse, followed
// by at least one idle arbitration cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : mem_request_arbiter_if.slave (requests, responses, RAM controls)
// Optional feature (macro MEM_ARB_STATS_EN):
//   icount[31:0], dcount[31:0] : completed instruction / data accesses
//   errcount[15:0]             : error or timeout completions
// Parameter:
//   TIMEOUT_CYCLES : cycles allowed in an access state before forced
//                    completion with error
// ---------------------------------------------------------------------------
module mem_request_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_request_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]          icount,
  output logic [31:0]          dcount,
  output logic [15:0]          errcount
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {IDLE, DACC, IACC, DRSP, IRSP} state_t;

  state_t            state, state_next;
  logic [31:0]       addr_q, store_q, iload_q, dload_q;
  logic              wr_q, mem_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_access, access_ok, access_fail, access_done;

  // A successful ACCESS takes priority over a timeout landing on the same cycle.
  always_comb begin
    in_access   = (state == DACC) || (state == IACC);
    access_ok   = in_access && (bus.ramstate == RAM_ACCESS);
    access_fail = in_access && !access_ok &&
                  ((bus.ramstate == RAM_ERROR) || (cnt_q == CNT_LAST));
    access_done = access_ok || access_fail;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) state_next = DACC;
        else if (bus.iREN)        state_next = IACC;
      end
      DACC:    if (access_done) state_next = DRSP;
      IACC:    if (access_done) state_next = IRSP;
      DRSP:    state_next = IDLE;
      IRSP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only at arbitration so that the RAM is driven
  // from stable values even if the requester changes or drops its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      store_q   <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (bus.dREN || bus.dWEN) begin
          addr_q  <= bus.daddr;
          store_q <= bus.dstore;
          wr_q    <= bus.dWEN;
        end else if (bus.iREN) begin
          addr_q  <= bus.iaddr;
          store_q <= '0;
          wr_q    <= 1'b0;
        end
      end

      if (in_access) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      if (access_ok && (state == IACC))          iload_q <= bus.ramload;
      if (access_ok && (state == DACC) && !wr_q) dload_q <= bus.ramload;

      if (access_fail) begin
        mem_err_q <= 1'b1;
        if (state == IACC) iload_q <= '0;
        else               dload_q <= '0;
      end
    end
  end

  assign bus.ramREN   = in_access && !wr_q;
  assign bus.ramWEN   = in_access && wr_q;
  assign bus.ramaddr  = in_access ? addr_q  : '0;
  assign bus.ramstore = in_access ? store_q : '0;
  assign bus.ihit     = (state == IRSP);
  assign bus.dhit     = (state == DRSP);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.mem_err  = mem_err_q;

`ifdef MEM_ARB_STATS_EN
  // Statistics counters wrap naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount   <= '0;
      dcount   <= '0;
      errcount <= '0;
    end else begin
      if (state == IRSP) icount   <= icount + 32'd1;
      if (state == DRSP) dcount   <= dcount + 32'd1;
      if (access_fail)   errcount <= errcount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_request_arbiter
// Self-checking bench for mem_request_arbiter with TIMEOUT_CYCLES = 4.
// Directed scenarios first, then randomized transactions. The reference model
// works per transaction: given how many BUSY cycles the RAM reports and how
// the access ends, it derives the number of access cycles, the hit, the
// returned load values and the sticky error flag.
// ---------------------------------------------------------------------------
module tb_mem_request_arbiter;

  localparam int TB_TIMEOUT = 4;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  logic [31:0] modelIload, modelDload;
  logic        modelErr;
  int          modelIcount, modelDcount, modelErrcount;

  mem_request_arbiter_if bus();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount, dcount;
  logic [15:0] errcount;
`endif

  mem_request_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount   (icount),
    .dcount   (dcount),
    .errcount (errcount)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic resetModel();
    modelIload    = '0;
    modelDload    = '0;
    modelErr      = 1'b0;
    modelIcount   = 0;
    modelDcount   = 0;
    modelErrcount = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hits"},     {30'b0, bus.ihit, bus.dhit}, 32'd0);
    checkOutput({tag, "_enables"},  {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
    checkOutput({tag, "_ramaddr"},  bus.ramaddr, 32'd0);
    checkOutput({tag, "_ramstore"}, bus.ramstore, 32'd0);
    checkOutput({tag, "_iload"},    bus.iload, 32'd0);
    checkOutput({tag, "_dload"},    bus.dload, 32'd0);
    checkOutput({tag, "_mem_err"},  {31'b0, bus.mem_err}, 32'd0);
  endtask

  // Idle arbitration cycle: no hit, RAM disabled, sticky error as modelled.
  task automatic checkIdle();
    checkOutput("idle_hits",    {30'b0, bus.ihit, bus.dhit}, 32'd0);
    checkOutput("idle_enables", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
    checkOutput("idle_mem_err", {31'b0, bus.mem_err}, {31'b0, modelErr});
  endtask

  // Called at the falling edge of the arbitration cycle with the request
  // already driven; returns at the falling edge of the response cycle.
  task automatic applyStimulus(input bit isData, input bit isWrite,
                               input logic [31:0] addr, input logic [31:0] store,
                               input int busyCycles, input bit failFinal,
                               input bit dropEarly, input logic [31:0] loadValue);
    bit timedOut;
    int accessCycles;
    timedOut     = (busyCycles > TB_TIMEOUT - 1);
    accessCycles = timedOut ? TB_TIMEOUT : busyCycles + 1;
    for (int k = 0; k < accessCycles; k++) begin
      @(negedge clk);
      bus.ramstate = (k < busyCycles) ? RS_BUSY : (failFinal ? RS_ERROR : RS_ACCESS);
      bus.ramload  = (k == busyCycles) ? loadValue : $urandom;
      checkOutput("access_hits", {30'b0, bus.ihit, bus.dhit}, 32'd0);
      checkOutput("ramaddr", bus.ramaddr, addr);
      checkOutput("ram_enables", {30'b0, bus.ramREN, bus.ramWEN}, {30'b0, !isWrite, isWrite});
      if (isWrite) checkOutput("ramstore", bus.ramstore, store);
      if (k == 0 && dropEarly) begin
        if (isData) begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
          bus.daddr = $urandom; bus.dstore = $urandom;
        end else begin
          bus.iREN = 1'b0; bus.iaddr = $urandom;
        end
      end
    end

    if (timedOut || failFinal) begin
      modelErr = 1'b1;
      modelErrcount++;
      if (isData) modelDload = '0;
      else        modelIload = '0;
    end else if (isData) begin
      if (!isWrite) modelDload = loadValue;
    end else begin
      modelIload = loadValue;
    end
    if (isData) modelDcount++;
    else        modelIcount++;

    @(negedge clk);
    bus.ramstate = RS_FREE;
    checkOutput(isData ? "dhit" : "ihit", {30'b0, bus.ihit, bus.dhit},
                isData ? 32'd1 : 32'd2);
    checkOutput("rsp_enables", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
    checkOutput("iload", bus.iload, modelIload);
    checkOutput("dload", bus.dload, modelDload);
    checkOutput("rsp_mem_err", {31'b0, bus.mem_err}, {31'b0, modelErr});
    if (isData) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
    else        bus.iREN = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = RS_FREE;
    resetModel();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Instruction fetch with two BUSY cycles.
    @(negedge clk); checkIdle();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 2, 1'b0, 1'b0, 32'h3C01ABCD);
    checkOutput("fetch_iload", bus.iload, 32'h3C01ABCD);

    // Simultaneous instruction and data read: data first.
    @(negedge clk); checkIdle();
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0, 32'h11112222);
    @(negedge clk); checkIdle();
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0, 0, 1'b0, 1'b0, 32'h33334444);

    // Data write.
    @(negedge clk); checkIdle();
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h55556666);

    // Timeout with RAM held BUSY.
    @(negedge clk); checkIdle();
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, TB_TIMEOUT + 3, 1'b0, 1'b0, 32'h77778888);
    checkOutput("timeout_dload", bus.dload, 32'd0);
    checkOutput("timeout_mem_err", {31'b0, bus.mem_err}, 32'd1);

    // Reset in the middle of an instruction access.
    @(negedge clk); checkIdle();
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    @(negedge clk); bus.ramstate = RS_BUSY;
    @(negedge clk);
    checkOutput("iacc_ramREN", {31'b0, bus.ramREN}, 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    bus.iREN = 1'b0; bus.ramstate = RS_FREE;
    resetModel();
    #1 rst = 1'b0;
    @(negedge clk); checkIdle();
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    applyStimulus(1'b0, 1'b0, 32'h48, 32'h0, 1, 1'b0, 1'b0, 32'h0BADF00D);

    // Randomized transactions.
    repeat (150) begin
      int          kind;
      bit          wantI, wantD, isWrite;
      logic [31:0] ia, da, ds;
      @(negedge clk); checkIdle();
      kind    = $urandom_range(0, 3);
      ia      = $urandom; da = $urandom; ds = $urandom;
      wantI   = (kind == 0) || (kind == 3);
      wantD   = (kind != 0);
      isWrite = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
      bus.iREN   = wantI; bus.iaddr = ia;
      bus.dWEN   = wantD && isWrite;
      bus.dREN   = wantD && (!isWrite || ($urandom_range(0, 1) == 1));
      bus.daddr  = da; bus.dstore = ds;
      if (wantD) begin
        applyStimulus(1'b1, isWrite, da, ds, $urandom_range(0, TB_TIMEOUT + 1),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), $urandom);
        if (wantI) begin
          @(negedge clk); checkIdle();
          applyStimulus(1'b0, 1'b0, ia, 32'h0, $urandom_range(0, TB_TIMEOUT + 1),
                        ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), $urandom);
        end
      end else begin
        applyStimulus(1'b0, 1'b0, ia, 32'h0, $urandom_range(0, TB_TIMEOUT + 1),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), $urandom);
      end
    end

    @(negedge clk); checkIdle();
`ifdef MEM_ARB_STATS_EN
    checkOutput("icount", icount, modelIcount);
    checkOutput("dcount", dcount, modelDcount);
    checkOutput("errcount", {16'b0, errcount}, modelErrcount & 32'hFFFF);
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
